// File: rtl/alu_arbiter.sv
// Two-port arbiter that time-shares one external combinational ALU. Define ALU_ARB_ROUND_ROBIN_EN for round-robin ties (default: port 0 priority).
// Accept in cycle N -> rsp_valid in N+2; new requests stall while busy, and the result is held until the winner's rsp_ready.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_b_0,
    input  logic [3:0]  req_op_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_1,
    input  logic [3:0]  req_op_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_result_0,
    output logic [31:0] rsp_result_1,
    output logic        rsp_zero_0,
    output logic        rsp_zero_1,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] opa_q, opb_q, res_q;
    logic [3:0]  op_q;
    logic        zero_q;
    logic        last_grant;
    logic        win;
    logic        accept;

    // last_grant doubles as the owner of the in-flight operation.
    always_comb begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (req_valid_0 && req_valid_1)
            win = ~last_grant;
        else
            win = ~req_valid_0;
`else
        win = ~req_valid_0;
`endif
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        rsp_valid_0 = 1'b0;
        rsp_valid_1 = 1'b0;
        case (state)
            IDLE: begin
                if ((req_valid_0 || req_valid_1) && !reset) begin
                    accept      = 1'b1;
                    req_ready_0 = ~win;
                    req_ready_1 = win;
                    state_nxt   = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid_0 = ~last_grant;
                rsp_valid_1 = last_grant;
                if (last_grant ? rsp_ready_1 : rsp_ready_0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            op_q       <= '0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                opa_q      <= win ? req_a_1  : req_a_0;
                opb_q      <= win ? req_b_1  : req_b_0;
                op_q       <= win ? req_op_1 : req_op_0;
                last_grant <= win;
            end
            if (state == EXEC) begin
                res_q  <= alu_result;
                zero_q <= alu_zero;
            end
        end
    end

    assign alu_a        = opa_q;
    assign alu_b        = opb_q;
    assign alu_op       = op_q;
    assign rsp_result_0 = res_q;
    assign rsp_result_1 = res_q;
    assign rsp_zero_0   = zero_q;
    assign rsp_zero_1   = zero_q;
    assign busy         = (state != IDLE);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 No parameters; data width fixed at 32 bits, ALU opcode fixed at 4 bits.
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid_0 / req_valid_1  input  1  requester n presents an operation.
REQ-005 req_ready_0 / req_ready_1  output  1  requester n operation accepted this cycle.
REQ-006 req_a_n, req_b_n  input  32  operands of requester n.
REQ-007 req_op_n  input  4  ALU opcode of requester n: 0000 and, 0001 or, 0010 add, 0110 sub, 1010 srl.
REQ-008 rsp_valid_n  output  1  result for requester n is available.
REQ-009 rsp_ready_n  input  1  requester n consumes the result.
REQ-010 rsp_result_n  output  32, rsp_zero_n  output  1  registered ALU result and zero flag.
REQ-011 alu_a, alu_b  output  32, alu_op  output  4  drive the shared ALU.
REQ-012 alu_result  input  32, alu_zero  input  1  combinational ALU outputs.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-015 IDLE: if any req_valid, select a winner, assert its req_ready combinationally in the same cycle, latch its a/b/op into operand registers, record winner id, go EXEC.
REQ-016 req_ready_n SHALL be high only in IDLE for the selected requester; never both high.
REQ-017 alu_a/alu_b/alu_op SHALL always equal the operand registers (stable from EXEC through RESP).
REQ-018 EXEC: capture alu_result and alu_zero into result registers, go RESP.
REQ-019 RESP: rsp_valid of recorded winner high, other rsp_valid low; hold result until rsp_ready of winner is high, then go IDLE.
REQ-020 Latency: acceptance in cycle N -> rsp_valid in cycle N+2; with rsp_ready held high, next acceptance no earlier than N+3.
REQ-021 Requests arriving while busy SHALL wait (req_ready low); requester holds inputs stable until accepted.
REQ-022 rsp_result/rsp_zero of both ports SHALL expose the same result registers; only rsp_valid differs.
REQ-023 Unsupported opcodes SHALL be passed through unmodified; result is whatever the ALU returns (0 for undecoded codes).
REQ-024 last_grant register updates on every acceptance to the winner id.

Reset
REQ-025 reset SHALL force state IDLE, abandon any in-flight operation, and clear operand/result registers to 0.
REQ-026 After reset: all req_ready and rsp_valid low until the first IDLE evaluation, busy 0, alu_a/alu_b 0, alu_op 0000, rsp_result 0, rsp_zero 0, last_grant 1.
REQ-027 reset asserted in EXEC or RESP SHALL suppress any rsp_valid in the following cycle.

Configuration
REQ-028 Macro ALU_ARB_ROUND_ROBIN_EN defined: on simultaneous requests the winner is the port not equal to last_grant; single request always wins.
REQ-029 Macro undefined: fixed priority, port 0 always wins ties; last_grant still maintained but unused.

Verification
REQ-030 Port 0 add: a=5, b=7, op=0010 at cycle N -> req_ready_0=1 at N, rsp_valid_0=1 at N+2, result=12, zero=0.
REQ-031 Port 1 sub: a=9, b=9, op=0110 -> rsp_valid_1=1, result=0, zero=1; rsp_valid_0 stays 0.
REQ-032 Both ports request continuously after reset with round-robin enabled -> grants alternate 0,1,0,1; without macro -> port 0 granted every time, port 1 starved.
REQ-033 Backpressure: rsp_ready_0=0 for 4 cycles during RESP -> rsp_valid_0 and result (srl 0x80000000 by 4 = 0x08000000) held stable, busy=1, port 1 req_ready=0.
REQ-034 reset asserted in EXEC of an add 1+1 -> next cycle state IDLE, no rsp_valid, rsp_result=0.
REQ-035 Port 0 or: a=0xF0F0F0F0, b=0x0F0F0F0F, op=0001 -> result 0xFFFFFFFF, zero=0.
